// File: rtl/resonant_pkg.sv
// Shared state encoding, default timing and counter sizing for the resonant calibration sequencer.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package resonant_pkg;

  localparam int DEF_BUS_WIDTH        = 10;
  localparam int DEF_SETUP_CYCLES     = 4;
  localparam int DEF_QUIET_CYCLES     = 64;
  localparam int DEF_MAX_BURST_CYCLES = 65535;
  localparam int DEF_GAP_CYCLES       = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    BURST,
    GAP,
    DECIDE,
    DONE
  } cal_state_t;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/resonant_pulse_counter.sv
// Synchronises q_serialized, counts its rising edges during a burst and decides when the burst ends.
// Latency: 2-cycle synchroniser before an edge is seen; burst_end is combinational on the registered timers.
// Backpressure: none; the pulse train is sampled every cycle and edges outside enable are not counted.
module resonant_pulse_counter
  import resonant_pkg::*;
#(
  parameter int BUS_WIDTH        = DEF_BUS_WIDTH,
  parameter int QUIET_CYCLES     = DEF_QUIET_CYCLES,
  parameter int MAX_BURST_CYCLES = DEF_MAX_BURST_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 q_serialized,
  output logic [BUS_WIDTH-1:0] count,
  output logic                 burst_end,
  output logic                 timed_out
);

  localparam int QW = cnt_width(QUIET_CYCLES);
  localparam int TW = cnt_width(MAX_BURST_CYCLES);
  localparam logic [QW-1:0]        QUIET_LAST = QW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0]        BURST_LAST = TW'(MAX_BURST_CYCLES - 1);
  localparam logic [BUS_WIDTH-1:0] CNT_MAX    = '1;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync_d;
  logic [BUS_WIDTH-1:0] r_count;
  logic [QW-1:0]        r_quiet;
  logic [TW-1:0]        r_burst;
  logic                 r_timed_out;

  logic w_edge;
  logic w_inc;
  logic w_quiet_hit;
  logic w_burst_hit;

  assign w_edge      = r_sync2 & ~r_sync_d;
  assign w_inc       = enable & w_edge & (r_count != CNT_MAX);
  // An edge landing on the quiet-limit cycle keeps the burst alive.
  assign w_quiet_hit = (r_quiet == QUIET_LAST) & ~w_edge;
  assign w_burst_hit = (r_burst == BURST_LAST);
  assign burst_end   = enable & (w_quiet_hit | w_burst_hit);
  // Count including this cycle's edge, so the final value is ready on the burst_end cycle.
  assign count       = r_count + {{(BUS_WIDTH-1){1'b0}}, w_inc};
  assign timed_out   = r_timed_out;

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= q_serialized;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  // Saturating edge count, quiet timer, burst timer and per-burst timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_quiet     <= '0;
      r_burst     <= '0;
      r_timed_out <= 1'b0;
    end else if (clear) begin
      r_count     <= '0;
      r_quiet     <= '0;
      r_burst     <= '0;
      r_timed_out <= 1'b0;
    end else if (enable) begin
      r_count <= count;
      r_quiet <= w_edge ? '0 : r_quiet + 1'b1;
      r_burst <= r_burst + 1'b1;
      if (w_burst_hit) begin
        r_timed_out <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/resonant_cal_ctrl.sv
// Successive-approximation search for the largest i_ref whose burst pulse count stays within target.
// Latency: BUS_WIDTH steps of SETUP + burst length + GAP + 1 cycles, then one DONE cycle.
// Backpressure: cal_req is only accepted in IDLE; requests while busy are dropped.
module resonant_cal_ctrl
  import resonant_pkg::*;
#(
  parameter int BUS_WIDTH        = DEF_BUS_WIDTH,
  parameter int SETUP_CYCLES     = DEF_SETUP_CYCLES,
  parameter int QUIET_CYCLES     = DEF_QUIET_CYCLES,
  parameter int MAX_BURST_CYCLES = DEF_MAX_BURST_CYCLES,
  parameter int GAP_CYCLES       = DEF_GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cal_req,
  input  logic [BUS_WIDTH-1:0] target_pulses,
  input  logic                 q_serialized,
  output logic [BUS_WIDTH-1:0] i_ref,
  output logic                 start,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic [BUS_WIDTH-1:0] i_ref_cal,
  output logic [BUS_WIDTH-1:0] pulse_cnt,
  output logic                 timeout_err
);

  localparam int BITW      = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
  localparam int PHASE_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int TW        = cnt_width(PHASE_MAX);
  localparam logic [TW-1:0]        SETUP_LAST = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0]        GAP_LAST   = TW'(GAP_CYCLES - 1);
  localparam logic [BITW-1:0]      BIT_MSB    = BITW'(BUS_WIDTH - 1);
  localparam logic [BUS_WIDTH-1:0] ONE        = {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  cal_state_t           r_state;
  cal_state_t           w_state_nxt;
  logic [BUS_WIDTH-1:0] r_code;
  logic [BUS_WIDTH-1:0] r_target;
  logic [BUS_WIDTH-1:0] r_i_ref_cal;
  logic [BUS_WIDTH-1:0] r_pulse_cnt;
  logic [BITW-1:0]      r_bit;
  logic [TW-1:0]        r_tmr;
  logic                 r_timeout_err;

  logic [BUS_WIDTH-1:0] w_trial;
  logic [BUS_WIDTH-1:0] w_code_dec;
  logic [BUS_WIDTH-1:0] w_i_ref;
  logic [BUS_WIDTH-1:0] w_count;
  logic                 w_keep;
  logic                 w_start;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_clear;
  logic                 w_enable;
  logic                 w_burst_end;
  logic                 w_timed_out;

  resonant_pulse_counter #(
    .BUS_WIDTH       (BUS_WIDTH),
    .QUIET_CYCLES    (QUIET_CYCLES),
    .MAX_BURST_CYCLES(MAX_BURST_CYCLES)
  ) u_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (w_clear),
    .enable      (w_enable),
    .q_serialized(q_serialized),
    .count       (w_count),
    .burst_end   (w_burst_end),
    .timed_out   (w_timed_out)
  );

  assign w_trial    = ONE << r_bit;
  // A timed-out burst never qualifies, whatever it counted.
  assign w_keep     = ~w_timed_out & (r_pulse_cnt <= r_target);
  assign w_code_dec = w_keep ? (r_code | w_trial) : r_code;

  assign i_ref       = w_i_ref;
  assign start       = w_start;
  assign cal_busy    = w_busy;
  assign cal_done    = w_done;
  assign i_ref_cal   = r_i_ref_cal;
  assign pulse_cnt   = r_pulse_cnt;
  assign timeout_err = r_timeout_err;

  // State register; reset forces IDLE so start and i_ref drop immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state drive of the resonant system and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_i_ref     = '0;
    w_start     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cal_req) begin
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        w_i_ref = r_code | w_trial;
        w_busy  = 1'b1;
        w_clear = 1'b1;
        if (r_tmr == SETUP_LAST) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        w_i_ref  = r_code | w_trial;
        w_start  = 1'b1;
        w_busy   = 1'b1;
        w_enable = 1'b1;
        if (w_burst_end) begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        w_i_ref = r_code | w_trial;
        w_busy  = 1'b1;
        if (r_tmr == GAP_LAST) begin
          w_state_nxt = DECIDE;
        end
      end
      DECIDE: begin
        w_i_ref     = r_code | w_trial;
        w_busy      = 1'b1;
        w_state_nxt = (r_bit == '0) ? DONE : ARM;
      end
      DONE: begin
        w_i_ref     = r_code;
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Phase timer for ARM and GAP; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmr <= '0;
    end else begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

  // SAR register, latched target, burst result and published calibration code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code        <= '0;
      r_target      <= '0;
      r_bit         <= '0;
      r_pulse_cnt   <= '0;
      r_i_ref_cal   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cal_req) begin
            r_target      <= target_pulses;
            r_code        <= '0;
            r_bit         <= BIT_MSB;
            r_timeout_err <= 1'b0;
          end
        end
        BURST: begin
          if (w_burst_end) begin
            r_pulse_cnt <= w_count;
          end
        end
        GAP: begin
          if (w_timed_out) begin
            r_timeout_err <= 1'b1;
          end
        end
        DECIDE: begin
          r_code <= w_code_dec;
          // Publish on the last step so i_ref_cal is already valid during DONE.
          if (r_bit == '0) begin
            r_i_ref_cal <= w_code_dec;
          end else begin
            r_bit <= r_bit - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resonant_cal_ctrl.sv
// Self-checking bench: emulated resonant system drives pulse bursts, scoreboards check every burst and result.
// Latency: calibrations are awaited with cycle budgets.
// Backpressure: requests are issued only while the DUT is idle, apart from the deliberate ignored request.
module tb_resonant_cal_ctrl;

  localparam int BW       = 10;
  localparam int SETUP    = 4;
  localparam int QUIET    = 64;
  localparam int MAXB     = 2500;
  localparam int GAPC     = 8;
  localparam int CODE_MAX = (1 << BW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cal_req;
  logic [BW-1:0] target_pulses;
  logic          q_serialized;
  logic [BW-1:0] i_ref;
  logic          start;
  logic          cal_busy;
  logic          cal_done;
  logic [BW-1:0] i_ref_cal;
  logic [BW-1:0] pulse_cnt;
  logic          timeout_err;

  resonant_cal_ctrl #(
    .BUS_WIDTH       (BW),
    .SETUP_CYCLES    (SETUP),
    .QUIET_CYCLES    (QUIET),
    .MAX_BURST_CYCLES(MAXB),
    .GAP_CYCLES      (GAPC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cal_req      (cal_req),
    .target_pulses(target_pulses),
    .q_serialized (q_serialized),
    .i_ref        (i_ref),
    .start        (start),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .i_ref_cal    (i_ref_cal),
    .pulse_cnt    (pulse_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int tmo;
  } res_t;

  int   total      = 0;
  int   bad        = 0;
  int   mode       = 0;   // 0: finite pulse bursts, 1: toggle for as long as start is high
  int   extra      = 0;   // 1: append one pulse exactly QUIET cycles after the last one
  int   burst_seen = 0;
  int   done_cnt   = 0;
  res_t res_q[$];
  int   exp_cnt_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Emulated system response: pulses per burst as a function of the reference code.
  function automatic int pulses_for(input int code);
    int p;
    p = code / 30;
    if (p < 1) p = 1;
    return p + extra;
  endfunction

  // Largest code whose response fits the target, found by exhaustive scan.
  function automatic int best_code(input int target);
    for (int c = CODE_MAX; c >= 0; c--) begin
      if (pulses_for(c) <= target) return c;
    end
    return 0;
  endfunction

  task automatic step(output bit alive);
    @(posedge clk);
    #1;
    alive = start;
  endtask

  task automatic hold(input bit lvl, input int n, inout bit alive);
    for (int k = 0; k < n && alive; k++) begin
      q_serialized = lvl;
      step(alive);
    end
  endtask

  // Resonant system model: reacts to each burst and records the count it will produce.
  initial begin : resonant_model
    bit alive;
    int n;
    q_serialized = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && start) begin
        burst_seen++;
        alive = 1'b1;
        if (mode == 1) begin
          exp_cnt_q.push_back(CODE_MAX);
          for (int k = 0; k < MAXB + 100 && alive; k++) begin
            q_serialized = ~q_serialized;
            step(alive);
          end
        end else begin
          n = pulses_for(int'(i_ref));
          exp_cnt_q.push_back(n);
          hold(1'b0, $urandom_range(1, 20), alive);
          for (int k = 0; k < n - extra; k++) begin
            hold(1'b1, 3, alive);
            hold(1'b0, 3, alive);
          end
          if (extra != 0) begin
            hold(1'b0, QUIET - 6, alive);
            hold(1'b1, 3, alive);
          end
          q_serialized = 1'b0;
          for (int k = 0; k < MAXB + 100 && alive; k++) begin
            step(alive);
          end
        end
        q_serialized = 1'b0;
      end
    end
  end

  // Monitor: checks pulse_cnt at every burst end and the result at every cal_done.
  initial begin : monitor
    bit   prev_start;
    res_t r;
    int   e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt_q.delete();
        res_q.delete();
        burst_seen = 0;
        prev_start = 1'b0;
      end else begin
        if (prev_start && !start) begin
          if (exp_cnt_q.size() == 0) begin
            chk("burst_expect_avail", exp_cnt_q.size(), 1);
          end else begin
            e = exp_cnt_q.pop_front();
            chk("pulse_cnt", int'(pulse_cnt), e);
          end
        end
        if (cal_done) begin
          done_cnt++;
          if (res_q.size() == 0) begin
            chk("done_expect_avail", res_q.size(), 1);
          end else begin
            r = res_q.pop_front();
            chk("i_ref_cal", int'(i_ref_cal), r.code);
            chk("timeout_err", int'(timeout_err), r.tmo);
            chk("bursts_per_cal", burst_seen, BW);
            chk("busy_at_done", int'(cal_busy), 0);
            chk("i_ref_at_done", int'(i_ref), r.code);
          end
          burst_seen = 0;
        end
        prev_start = start;
      end
    end
  end

  // Issue one calibration (optionally with an ignored request mid-run) and wait for it.
  task automatic run_cal(input int target, input int exp_code, input int exp_tmo, input int glitch_target);
    int   d0;
    bit   got;
    res_t r;
    d0 = done_cnt;
    r.code = exp_code;
    r.tmo  = exp_tmo;
    res_q.push_back(r);
    target_pulses = BW'(target);
    cal_req = 1'b1;
    @(posedge clk);
    #1;
    cal_req = 1'b0;
    chk("busy_after_req", int'(cal_busy), 1);
    chk("tmo_clear_on_req", int'(timeout_err), 0);
    got = 1'b0;
    for (int i = 0; i < 40000 && !got; i++) begin
      if (i == 300 && glitch_target >= 0) begin
        target_pulses = BW'(glitch_target);
        cal_req = 1'b1;
      end else begin
        cal_req = 1'b0;
      end
      @(posedge clk);
      #1;
      got = (done_cnt != d0);
    end
    cal_req = 1'b0;
    chk("cal_done_seen", done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("cal_done_once", done_cnt - d0, 1);
  endtask

  initial begin : stimulus
    int t;
    int d0;
    rst_n = 1'b0;
    cal_req = 1'b0;
    target_pulses = '0;
    #1;
    chk("rst_start", int'(start), 0);
    chk("rst_i_ref", int'(i_ref), 0);
    chk("rst_busy", int'(cal_busy), 0);
    chk("rst_done", int'(cal_done), 0);
    chk("rst_i_ref_cal", int'(i_ref_cal), 0);
    chk("rst_pulse_cnt", int'(pulse_cnt), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_cal(10, 329, 0, -1);
    run_cal(0, 0, 0, -1);
    run_cal(1023, 1023, 0, -1);
    // A second request with target 0 arrives mid-run and must not change the outcome.
    run_cal(10, 329, 0, 0);

    // Extra pulse on the quiet-limit cycle must be counted.
    extra = 1;
    run_cal(10, best_code(10), 0, -1);
    extra = 0;

    // Continuous toggling: every burst times out and saturates the count.
    mode = 1;
    run_cal(10, 0, 1, -1);
    mode = 0;
    chk("tmo_sticky_idle", int'(timeout_err), 1);

    t = $urandom_range(1, 30);
    run_cal(t, best_code(t), 0, -1);
    t = $urandom_range(0, 40);
    run_cal(t, best_code(t), 0, -1);

    // Reset in the middle of the third burst.
    d0 = done_cnt;
    target_pulses = BW'(10);
    cal_req = 1'b1;
    @(posedge clk);
    #1;
    cal_req = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (burst_seen >= 3) break;
      @(posedge clk);
      #1;
    end
    chk("reached_burst3", burst_seen, 3);
    repeat (5) @(posedge clk);
    #3;
    chk("start_before_rst", int'(start), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_start", int'(start), 0);
    chk("rst_mid_i_ref", int'(i_ref), 0);
    chk("rst_mid_busy", int'(cal_busy), 0);
    chk("rst_mid_i_ref_cal", int'(i_ref_cal), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("idle_after_rst", int'(cal_busy), 0);
    run_cal(10, 329, 0, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("leftover_cnt_q", exp_cnt_q.size(), 0);
    chk("leftover_res_q", res_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/resonant_cal_ctrl.md
Name: resonant_cal_ctrl

Overview:
- Closed-loop calibration sequencer for the resonant system emulation block.
- Drives `i_ref` and `start` into the resonant system and counts the `q_serialized` pulses each burst returns.
- Runs a BUS_WIDTH-step successive-approximation search for the largest `i_ref` code whose burst pulse count does not exceed a requested target.
- Publishes the result for downstream charge-delivery logic.

Parameters:
- BUS_WIDTH, 10, width of `i_ref`, target and count buses.
- SETUP_CYCLES, 4, cycles `i_ref` is held stable with `start` low before each burst.
- QUIET_CYCLES, 64, cycles without a detected pulse edge that end a burst.
- MAX_BURST_CYCLES, 65535, hard limit on cycles spent in one burst before timeout.
- GAP_CYCLES, 8, cycles `start` is held low after each burst so the emulated system re-arms.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cal_req  input  1  single-cycle request to start a calibration; ignored while busy.
- target_pulses  input  BUS_WIDTH  maximum acceptable pulses per burst; sampled on an accepted cal_req.
- q_serialized  input  1  asynchronous pulse train from the resonant system.
- i_ref  output  BUS_WIDTH  trial reference code to the resonant system.
- start  output  1  burst enable to the resonant system.
- cal_busy  output  1  high from the cycle after cal_req acceptance until DONE.
- cal_done  output  1  single-cycle pulse when i_ref_cal becomes valid.
- i_ref_cal  output  BUS_WIDTH  calibrated code; holds until the next completed calibration.
- pulse_cnt  output  BUS_WIDTH  pulse count of the most recent burst, saturating.
- timeout_err  output  1  sticky; set if any burst hit MAX_BURST_CYCLES; cleared on accepted cal_req.

Behaviour:
- Reset values: all outputs 0; state IDLE; synchronizer flops 0.
  - Reset asserted mid-burst drops `start` and `i_ref` to 0 asynchronously and discards any partial result.
- Input conditioning: `q_serialized` passes through a 2-flop synchronizer. A rising edge of the synchronized signal is one pulse.
- IDLE:
  - On cal_req: latch target, set `code` = 0 and `bit` = BUS_WIDTH-1, clear timeout_err, go to ARM.
  - cal_req in any other state is ignored.
- ARM:
  - `i_ref` = `code` | (1<<`bit`), `start` = 0.
  - Counters cleared.
  - After SETUP_CYCLES, go to BURST.
- BURST: `start` = 1; count rising edges, saturating at 2^BUS_WIDTH-1.
  - The quiet timer restarts on BURST entry and on every edge.
  - Quiet timer reaches QUIET_CYCLES: go to GAP with `timed_out` = 0.
  - Burst timer reaches MAX_BURST_CYCLES first: go to GAP with `timed_out` = 1 and set timeout_err.
  - An edge in the same cycle as the quiet limit counts and restarts the timer.
- GAP:
  - `start` = 0; `i_ref` is held.
  - `pulse_cnt` is updated with the final count on GAP entry.
  - After GAP_CYCLES, go to DECIDE.
- DECIDE (1 cycle):
  - Keep the trial bit in `code` iff `timed_out` = 0 and count <= target.
  - If `bit` = 0, go to DONE; otherwise decrement `bit` and go to ARM.
- DONE (1 cycle):
  - `i_ref_cal` = `code`; `cal_done` = 1; `i_ref` = `code`; `start` = 0.
  - Go to IDLE; `cal_busy` drops the same cycle `cal_done` is high.
- Latency: exactly BUS_WIDTH bursts per calibration. Per-step cycles = SETUP + burst length + GAP + 1 (DECIDE).
- Search assumption: the pulse count is monotonic non-decreasing in `i_ref`. No result is guaranteed otherwise.
- Boundary conditions:
  - A zero-pulse burst counts 0 and ends after QUIET_CYCLES.
  - target = 0 against a system emitting at least 1 pulse gives `i_ref_cal` = 0.
  - target = all-ones keeps every bit.

Decomposition:
- Package `resonant_pkg` holds:
  - the state enum (IDLE, ARM, BURST, GAP, DECIDE, DONE);
  - the default timing constants;
  - a counter-width function (clog2 of MAX_BURST_CYCLES+1).
- Sub-module `resonant_pulse_counter` contains the synchronizer, edge detect, saturating count, quiet timer and burst timer.
  - Inputs: `clear`, `enable`. Outputs: `count`, `burst_end`, `timed_out`.
- The FSM and SAR register live in `resonant_cal_ctrl`.

Test Plan:
- Bench model: pulses = max(1, i_ref/30), pulse period 6 cycles. target_pulses = 10 -> i_ref_cal = 329, cal_done once, 10 bursts, timeout_err = 0.
- Same model, target_pulses = 0 -> every bit rejected, i_ref_cal = 0. target_pulses = 1023 -> i_ref_cal = 1023.
- Model toggles q_serialized continuously while start is high -> every burst times out, timeout_err = 1, i_ref_cal = 0. A following cal_req clears timeout_err.
- Deassert rst_n during the 3rd burst -> start and i_ref go to 0 immediately, cal_busy = 0, no cal_done. A new cal_req after release completes normally with the expected result.
- Pulse cal_req again while busy with a different target -> ignored; the original target's result is produced. Pulse edge coincident with the quiet-limit cycle -> counted, pulse_cnt matches the model.
